isp_win3x3: RTL
===============

// Module: isp_win3x3
// PURPOSE
//  Streaming 3x3 window generator, directly downstream of isp_csc: consumes its
//  8-bit gray pixel stream (valid/ready), buffers two previous lines and emits
//  one 3x3 neighbourhood per interior pixel to the Sobel stage. Raster order,
//  fixed frame size; frame position is tracked internally by column/row counters.
// PARAMETERS
//  IMG_W    1920  pixels per line (>=3)
//  IMG_H    1080  lines per frame (>=3)
//  PIX_W    8     bits per gray pixel
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        asynchronous, active-high reset
//  data_m_gray  in   PIX_W    input pixel (from isp_csc data_s_gray)
//  valid_m      in   1        input pixel valid
//  ready_m      out  1        block can accept input pixel
//  data_s_win   out  9*PIX_W  window; pixel (row i, col j), i,j in 0..2, 0=top/left,
//                             at bits [PIX_W*(3*i+j) +: PIX_W]; (2,2)=newest pixel
//  valid_s      out  1        window valid
//  ready_s      in   1        downstream can accept window
// BEHAVIOUR
//  - Reset: valid_s=0, data_s_win=0, col=0, row=0, window regs=0; line buffers
//    not cleared (contents irrelevant, masked by row/col gating). ready_m=1 after reset.
//  - Accept: acc = valid_m & ready_m. ready_m = ~valid_s | ready_s (one output
//    register, full throughput, combinational ready path). Nothing changes when acc=0.
//  - Line buffers: lb1 (line r-1), lb2 (line r-2), IMG_W deep each, indexed by col.
//    On acc: lb2[col]<=lb1[col]; lb1[col]<=data_m_gray (read-before-write, same cycle).
//  - Window regs shift left one column on acc; new right column =
//    {top: lb2[col], mid: lb1[col], bottom: data_m_gray}.
//  - Counters on acc: col++; col==IMG_W-1 -> col=0, row++; at (IMG_W-1, IMG_H-1)
//    both wrap to 0 (next pixel = new frame, no idle required).
//  - Output: on acc of pixel at (row,col) with row>=2 and col>=2, next cycle
//    valid_s=1 and data_s_win = rows row-2..row, cols col-2..col. Latency 1 cycle.
//    Windows straddling a line start (col<2) or in rows 0-1 are never emitted.
//    Per frame exactly (IMG_W-2)*(IMG_H-2) windows.
//  - valid_s clears when ready_s=1 and no new qualifying acc that cycle; if
//    ready_s=1 and qualifying acc coincide, valid_s stays 1 with new data.
//  - Backpressure: valid_s=1 & ready_s=0 -> ready_m=0; data_s_win, valid_s held
//    stable until taken. Non-qualifying acc cycles (row<2 or col<2) still require
//    ready_m; no bubbles inserted.
//  - Reset mid-frame: all state as above at once; next accepted pixel is (0,0)
//    of a new frame; in-flight window discarded.
//  - Pure pass of values: no arithmetic, no clipping; widths fixed by PIX_W.
// TESTING
//  (IMG_W=8, IMG_H=4, pixel(r,c)=16*r+c unless noted)
//  1 Full-rate frame, ready_s=1 -> 12 windows; first after pixel(2,2):
//    rows {00,01,02},{10,11,12},{20,21,22}; last centre (2,6) bottom-right 0x37.
//  2 Random valid_m gaps (50%) -> identical 12 windows in same order, 1-cycle latency.
//  3 ready_s low 5 cycles while valid_s=1 -> ready_m=0, data_s_win held, no
//    window lost or duplicated; total still 12.
//  4 Two frames back-to-back, frame 2 pixels +0x80 -> 24 windows, frame-2 windows
//    contain only frame-2 values (no row 3 of frame 1 emitted as top rows).
//  5 Assert rst after pixel (2,4), then resend frame -> no valid_s until pixel
//    (2,2) of new frame; then 12 correct windows.
//  6 Randomised valid_m/ready_s 10k cycles vs software 3x3 model -> zero mismatches.

Source files
------------

// File: rtl/isp_win3x3.sv
// ---------------------------------------------------------------------------
// isp_win3x3
// Streaming 3x3 window generator. It takes a raster-order gray pixel stream,
// keeps the two previous lines in line buffers, and emits one 3x3
// neighbourhood for each interior pixel (row >= 2, col >= 2). The frame
// position comes from internal column/row counters.
//
// Ports
//   clk          in   1        system clock, rising edge
//   rst          in   1        asynchronous, active-high reset
//   data_m_gray  in   PIX_W    input pixel
//   valid_m      in   1        input pixel valid
//   ready_m      out  1        block can accept an input pixel
//   data_s_win   out  9*PIX_W  window; pixel (row i, col j) is at
//                              [PIX_W*(3*i+j) +: PIX_W]; (2,2) = newest pixel
//   valid_s      out  1        window valid
//   ready_s      in   1        downstream can accept the window
// ---------------------------------------------------------------------------
module isp_win3x3 #(
    parameter int IMG_W = 1920,
    parameter int IMG_H = 1080,
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   data_m_gray,
    input  logic               valid_m,
    output logic               ready_m,
    output logic [9*PIX_W-1:0] data_s_win,
    output logic               valid_s,
    input  logic               ready_s
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // Window as [row][col][bit]. The packed layout puts element (i,j) at
    // offset PIX_W*(3*i+j), which is exactly the output bus layout.
    typedef logic [2:0][2:0][PIX_W-1:0] win_t;

    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    win_t               win_q, win_d;
    logic               valid_s_q, valid_s_d;
    logic [9*PIX_W-1:0] data_s_win_q, data_s_win_d;

    logic [PIX_W-1:0]   lb1_q [IMG_W];   // line r-1
    logic [PIX_W-1:0]   lb2_q [IMG_W];   // line r-2
    logic [PIX_W-1:0]   lb1_rd, lb2_rd;

    logic acc;
    logic qual;

    // The output register is the only buffering stage. It can take a new
    // window whenever it is empty or is being drained in this cycle.
    assign ready_m = ~valid_s_q | ready_s;
    assign acc     = valid_m & ready_m;
    // Only pixels with a full 3x3 neighbourhood in the current frame
    // produce a window.
    assign qual    = acc & (row_q >= RW'(2)) & (col_q >= CW'(2));

    assign lb1_rd  = lb1_q[col_q];
    assign lb2_rd  = lb2_q[col_q];

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        valid_s_d    = valid_s_q;
        data_s_win_d = data_s_win_q;

        if (acc) begin
            // Shift the window one column left and bring in the new right column.
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb2_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = data_m_gray;

            // Raster position. The last pixel of a frame wraps both counters,
            // so the next accepted pixel is (0,0) of the next frame.
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (qual) begin
            valid_s_d    = 1'b1;
            data_s_win_d = win_d;
        end else if (ready_s) begin
            valid_s_d    = 1'b0;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            valid_s_q    <= 1'b0;
            data_s_win_q <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            valid_s_q    <= valid_s_d;
            data_s_win_q <= data_s_win_d;
        end
    end

    // NOTE: the line buffers have no reset. Stale contents are never emitted,
    // because the row/col gating masks them, and leaving them unreset keeps
    // them mappable to RAM.
    // Read-before-write: lb2 takes the old lb1 entry in the same cycle that
    // lb1 takes the new pixel.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb2_q[col_q] <= lb1_rd;
            lb1_q[col_q] <= data_m_gray;
        end
    end

    assign valid_s    = valid_s_q;
    assign data_s_win = data_s_win_q;

endmodule
